// File: rtl/cps_snd_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : cps_snd_mailbox
// Purpose  : 68K-to-Z80 sound command mailbox for the CPS audio subsystem,
//            clocked by the audio clock. Channel 0 is a command-byte FIFO, so
//            back-to-back host writes are not lost. Channels 1..NUM_CH-1 are
//            plain latches (fade, volume, spare). The Z80 interrupt is held
//            low while commands are pending. The host side sees a sticky
//            overflow flag and a fill count.
// Option   : `define CPS_SND_REPLY_EN enables the Z80->host reply latch.
//            When it is not defined, the reply outputs are tied to 0 and no
//            reply registers exist.
// Ports    : clock, reset_n (async, active-low)
//            host_wr/host_addr/host_din         host write port
//            host_full/host_count/host_ovf      host status (registered)
//            host_ovf_clr                       clears sticky overflow
//            z80_rd/z80_addr -> z80_dout        Z80 read port (1-cycle latency)
//            z80_irq_n                          low while the FIFO is non-empty
//            z80_wr/z80_din                     Z80 reply write (option)
//            host_reply/host_reply_vld/_ack     host reply side (option)
// Revision : 1.0 - initial release
// ============================================================================
module cps_snd_mailbox #(
    parameter int                DATA_W     = 8,
    parameter int                NUM_CH     = 2,
    parameter int                CH_AW      = 1,
    parameter int                FIFO_DEPTH = 4,
    parameter int                CNT_W      = 3,
    parameter logic [DATA_W-1:0] EMPTY_VAL  = 8'hFF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              host_wr,
    input  logic [CH_AW-1:0]  host_addr,
    input  logic [DATA_W-1:0] host_din,
    output logic              host_full,
    output logic [CNT_W-1:0]  host_count,
    output logic              host_ovf,
    input  logic              host_ovf_clr,
    input  logic              z80_rd,
    input  logic [CH_AW-1:0]  z80_addr,
    output logic [DATA_W-1:0] z80_dout,
    output logic              z80_irq_n,
    input  logic              z80_wr,
    input  logic [DATA_W-1:0] z80_din,
    output logic [DATA_W-1:0] host_reply,
    output logic              host_reply_vld,
    input  logic              host_reply_ack
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q   [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d   [FIFO_DEPTH];
    logic [DATA_W-1:0] latch_q [1:NUM_CH-1];
    logic [DATA_W-1:0] latch_d [1:NUM_CH-1];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [DATA_W-1:0] dout_q,   dout_d;
    logic              irq_n_q,  irq_n_d;
    logic              full_q,   full_d;
    logic              ovf_q,    ovf_d;

    logic              w_push;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_ovf_set;
    logic [DATA_W-1:0] w_rd_data;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_push = host_wr && (host_addr == '0);
        // A pop only happens when there is something to pop; an empty read
        // returns EMPTY_VAL and leaves the pointers alone.
        w_pop  = z80_rd && (z80_addr == '0) && (count_q != '0);
        // full_q mirrors count_q == FIFO_DEPTH. A same-cycle pop frees the
        // slot, so a write against a full FIFO is still accepted then.
        w_push_ok = w_push && (!full_q || w_pop);
        w_ovf_set = w_push && full_q && !w_pop;

        // Read mux: FIFO head / latch / zero for unmapped channels.
        w_rd_data = '0;
        if (z80_addr == '0) begin
            w_rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : EMPTY_VAL;
        end else begin
            for (int i = 1; i < NUM_CH; i++) begin
                if (z80_addr == CH_AW'(i)) begin
                    w_rd_data = latch_q[i];
                end
            end
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push_ok) begin
            mem_d[wr_ptr_q] = host_din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        count_d = count_q;
        if (w_push_ok && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!w_push_ok && w_pop) begin
            count_d = count_q - CNT_W'(1);
        end

        // Latches are written after the read mux samples them, so a
        // same-cycle read of the same latch returns the old value.
        latch_d = latch_q;
        for (int i = 1; i < NUM_CH; i++) begin
            if (host_wr && (host_addr == CH_AW'(i))) begin
                latch_d[i] = host_din;
            end
        end

        dout_d = z80_rd ? w_rd_data : dout_q;

        // Status flags reflect the post-edge fill level.
        full_d  = (count_d == C_DEPTH);
        irq_n_d = (count_d == '0);

        // Overflow set has priority over clear.
        if (w_ovf_set) begin
            ovf_d = 1'b1;
        end else if (host_ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int i = 1; i < NUM_CH; i++) begin
                latch_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= EMPTY_VAL;
            irq_n_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            latch_q  <= latch_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            irq_n_q  <= irq_n_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    assign host_full  = full_q;
    assign host_count = count_q;
    assign host_ovf   = ovf_q;
    assign z80_dout   = dout_q;
    assign z80_irq_n  = irq_n_q;

    // ------------------------------------------------------------------
    // Optional Z80 -> host reply latch
    // ------------------------------------------------------------------
`ifdef CPS_SND_REPLY_EN
    logic [DATA_W-1:0] reply_q, reply_d;
    logic              reply_vld_q, reply_vld_d;

    // A same-cycle reply write beats the acknowledge.
    always_comb begin
        reply_d     = reply_q;
        reply_vld_d = reply_vld_q;
        if (z80_wr) begin
            reply_d     = z80_din;
            reply_vld_d = 1'b1;
        end else if (host_reply_ack) begin
            reply_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reply_q     <= '0;
            reply_vld_q <= 1'b0;
        end else begin
            reply_q     <= reply_d;
            reply_vld_q <= reply_vld_d;
        end
    end

    assign host_reply     = reply_q;
    assign host_reply_vld = reply_vld_q;
`else
    // Reply inputs have no function in this build.
    logic w_unused_reply;
    assign w_unused_reply = ^{z80_wr, z80_din, host_reply_ack};

    assign host_reply     = '0;
    assign host_reply_vld = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cps_snd_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_cps_snd_mailbox
// Purpose  : Self-checking bench for cps_snd_mailbox. Directed steps from the
//            test plan followed by a randomized phase, all compared against a
//            queue-based reference model of the mailbox.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cps_snd_mailbox;

    localparam int DATA_W = 8;
    localparam int NUM_CH = 3;
    localparam int CH_AW  = 2;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              host_wr;
    logic [CH_AW-1:0]  host_addr;
    logic [DATA_W-1:0] host_din;
    logic              host_full;
    logic [CNT_W-1:0]  host_count;
    logic              host_ovf;
    logic              host_ovf_clr;
    logic              z80_rd;
    logic [CH_AW-1:0]  z80_addr;
    logic [DATA_W-1:0] z80_dout;
    logic              z80_irq_n;
    logic              z80_wr;
    logic [DATA_W-1:0] z80_din;
    logic [DATA_W-1:0] host_reply;
    logic              host_reply_vld;
    logic              host_reply_ack;

    always #5 clock = ~clock;

    cps_snd_mailbox #(
        .DATA_W     (DATA_W),
        .NUM_CH     (NUM_CH),
        .CH_AW      (CH_AW),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W),
        .EMPTY_VAL  (8'hFF)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .host_wr        (host_wr),
        .host_addr      (host_addr),
        .host_din       (host_din),
        .host_full      (host_full),
        .host_count     (host_count),
        .host_ovf       (host_ovf),
        .host_ovf_clr   (host_ovf_clr),
        .z80_rd         (z80_rd),
        .z80_addr       (z80_addr),
        .z80_dout       (z80_dout),
        .z80_irq_n      (z80_irq_n),
        .z80_wr         (z80_wr),
        .z80_din        (z80_din),
        .host_reply     (host_reply),
        .host_reply_vld (host_reply_vld),
        .host_reply_ack (host_reply_ack)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the FIFO is a plain queue of bytes.
    logic [7:0] m_q [$];
    logic [7:0] m_lat [NUM_CH];
    logic       m_ovf;
    logic [7:0] m_dout;
    logic [7:0] m_reply;
    logic       m_vld;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < NUM_CH; i++) m_lat[i] = 8'h00;
        m_ovf   = 1'b0;
        m_dout  = 8'hFF;
        m_reply = 8'h00;
        m_vld   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_dout"},  32'(z80_dout),       32'(m_dout));
        check({tag, "_count"}, 32'(host_count),     32'(m_q.size()));
        check({tag, "_full"},  32'(host_full),      32'(m_q.size() == DEPTH));
        check({tag, "_irqn"},  32'(z80_irq_n),      32'(m_q.size() == 0));
        check({tag, "_ovf"},   32'(host_ovf),       32'(m_ovf));
        check({tag, "_reply"}, 32'(host_reply),     32'(m_reply));
        check({tag, "_rvld"},  32'(host_reply_vld), 32'(m_vld));
    endtask

    // One clock cycle of stimulus, model update and full output check.
    task automatic step(input string tag,
                        input logic wr, input logic [1:0] wa, input logic [7:0] wd,
                        input logic rd, input logic [1:0] ra,
                        input logic clr,
                        input logic zwr, input logic [7:0] zd, input logic ack);
        logic ovf_set;
        host_wr        = wr;
        host_addr      = wa;
        host_din       = wd;
        z80_rd         = rd;
        z80_addr       = ra;
        host_ovf_clr   = clr;
        z80_wr         = zwr;
        z80_din        = zd;
        host_reply_ack = ack;
        @(posedge clock);
        #1;
        host_wr = 1'b0; z80_rd = 1'b0; host_ovf_clr = 1'b0;
        z80_wr = 1'b0; host_reply_ack = 1'b0;

        ovf_set = 1'b0;
        if (rd) begin
            if (ra == 0)           m_dout = (m_q.size() > 0) ? m_q.pop_front() : 8'hFF;
            else if (ra < NUM_CH)  m_dout = m_lat[ra];
            else                   m_dout = 8'h00;
        end
        if (wr) begin
            if (wa == 0) begin
                if (m_q.size() < DEPTH) m_q.push_back(wd);
                else                    ovf_set = 1'b1;
            end else if (wa < NUM_CH) begin
                m_lat[wa] = wd;
            end
        end
        if (ovf_set)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
`ifdef CPS_SND_REPLY_EN
        if (zwr) begin
            m_reply = zd;
            m_vld   = 1'b1;
        end else if (ack) begin
            m_vld = 1'b0;
        end
`endif
        check_all(tag);
    endtask

    task automatic hw(input string tag, input logic [1:0] a, input logic [7:0] d);
        step(tag, 1'b1, a, d, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic zr(input string tag, input logic [1:0] a);
        step(tag, 1'b0, 2'd0, 8'h00, 1'b1, a, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        host_wr = 1'b0; host_addr = '0; host_din = '0; host_ovf_clr = 1'b0;
        z80_rd = 1'b0; z80_addr = '0; z80_wr = 1'b0; z80_din = '0; host_reply_ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // 1. Empty read
        zr("t1_rd_empty", 2'd0);
        check("t1_dout_ff", 32'(z80_dout), 32'h0000_00FF);

        // 2. Three commands in, three out, then empty
        hw("t2_wr_f0", 2'd0, 8'hF0);
        hw("t2_wr_f7", 2'd0, 8'hF7);
        hw("t2_wr_09", 2'd0, 8'h09);
        check("t2_count3", 32'(host_count), 32'd3);
        zr("t2_rd1", 2'd0);
        check("t2_first", 32'(z80_dout), 32'h0000_00F0);
        zr("t2_rd2", 2'd0);
        zr("t2_rd3", 2'd0);
        check("t2_irqn_after3", 32'(z80_irq_n), 32'd1);
        zr("t2_rd4", 2'd0);

        // 3. Overflow at depth 4 and overflow clear
        for (int i = 1; i <= 5; i++) hw("t3_wr", 2'd0, 8'(i));
        check("t3_ovf", 32'(host_ovf), 32'd1);
        for (int i = 0; i < 4; i++) zr("t3_rd", 2'd0);
        check("t3_last", 32'(z80_dout), 32'h0000_0004);
        step("t3_clr", 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        // Clear and overflow in the same cycle: set wins
        for (int i = 0; i < 4; i++) hw("t3_fill", 2'd0, 8'h20 + 8'(i));
        step("t3_setwins", 1'b1, 2'd0, 8'h77, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0);
        step("t3_clr2", 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0);

        // 4. Full FIFO, simultaneous push and pop
        step("t4_pushpop", 1'b1, 2'd0, 8'h0A, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("t4_count4", 32'(host_count), 32'd4);
        for (int i = 0; i < 4; i++) zr("t4_drain", 2'd0);
        check("t4_tail0a", 32'(z80_dout), 32'h0000_000A);
        // Empty FIFO, simultaneous push and pop: no bypass
        step("t4_empty_pp", 1'b1, 2'd0, 8'h5E, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0);

        // 5. Latch channels, unmapped channel, same-cycle read/write
        hw("t5_wr_l1", 2'd1, 8'h3C);
        zr("t5_rd_l1a", 2'd1);
        zr("t5_rd_l1b", 2'd1);
        check("t5_l1", 32'(z80_dout), 32'h0000_003C);
        step("t5_rw_same", 1'b1, 2'd1, 8'h99, 1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0);
        hw("t5_wr_l2", 2'd2, 8'hA5);
        hw("t5_wr_l3", 2'd3, 8'hEE);
        zr("t5_rd_l3", 2'd3);
        zr("t5_rd_l2", 2'd2);
        hw("t5_q1", 2'd0, 8'h31);
        // Asynchronous reset mid-sequence, checked before any clock edge
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("t5_rst_mid");
        @(negedge clock);
        reset_n = 1'b1;
        zr("t5_after_rst", 2'd0);

        // 6. Reply latch
        step("t6_zwr", 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 8'h5A, 1'b0);
        step("t6_ack", 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1);
        step("t6_zwr2", 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 8'hC3, 1'b0);
        step("t6_both", 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1, 8'h81, 1'b1);

        // Randomized phase
        for (int n = 0; n < 400; n++) begin
            step("rand",
                 1'($urandom_range(0, 99) < 50), 2'($urandom), 8'($urandom),
                 1'($urandom_range(0, 99) < 40), 2'($urandom),
                 1'($urandom_range(0, 99) < 8),
                 1'($urandom_range(0, 99) < 15), 8'($urandom),
                 1'($urandom_range(0, 99) < 20));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cps_snd_mailbox.md
Name: cps_snd_mailbox

Overview:
- Parametrised 68K-to-Z80 sound command mailbox for the CPS audio subsystem, clocked by the audio clock.
- Channel 0 is a FIFO of command bytes, so back-to-back host writes are not lost. Channels 1..NUM_CH-1 are plain latches: fade, volume and spare registers.
- The block drives the Z80 interrupt while commands are pending, and keeps overflow status and a fill count for the host side.

Parameters:
- DATA_W, 8: width of command/latch data.
- NUM_CH, 2: number of channels; channel 0 = FIFO, the rest = latches; range 2..8.
- CH_AW, 1: channel address width; must satisfy 2**CH_AW >= NUM_CH.
- FIFO_DEPTH, 4: channel-0 FIFO entries; power of 2, range 2..64.
- CNT_W, 3: fill-count width; equals log2(FIFO_DEPTH)+1.
- EMPTY_VAL, 8'hFF: value returned when channel 0 is read while empty.

Ports:
- clock  in  1  audio clock.
- reset_n  in  1  asynchronous, active-low reset.
- host_wr  in  1  single-cycle write strobe, synchronous to clock.
- host_addr  in  CH_AW  channel select for a host write.
- host_din  in  DATA_W  host write data.
- host_full  out  1  channel-0 FIFO full.
- host_count  out  CNT_W  channel-0 fill level, 0..FIFO_DEPTH.
- host_ovf  out  1  sticky overflow flag.
- host_ovf_clr  in  1  clears host_ovf.
- z80_rd  in  1  single-cycle read strobe (edge-qualified by the parent).
- z80_addr  in  CH_AW  channel select for a Z80 read.
- z80_dout  out  DATA_W  registered read data.
- z80_irq_n  out  1  low while the FIFO is non-empty.
- z80_wr  in  1  reply write strobe (used only with the optional feature).
- z80_din  in  DATA_W  reply data.
- host_reply  out  DATA_W  reply latch contents.
- host_reply_vld  out  1  reply pending.
- host_reply_ack  in  1  clears host_reply_vld.

Behaviour:
- Reset (reset_n low, async) sets:
  - FIFO pointers and count to 0; all latches to 0.
  - z80_dout = EMPTY_VAL, z80_irq_n = 1, host_full = 0, host_ovf = 0.
  - host_reply = 0, host_reply_vld = 0.
- Reset mid-operation discards all queued data. No partial state survives.
- Host write, addr 0:
  - If not full: push host_din at the write pointer; write pointer wraps modulo FIFO_DEPTH.
  - If full and no simultaneous pop: data dropped, host_ovf set.
- Host write, addr 1..NUM_CH-1: latch updated next edge.
- Host write, addr >= NUM_CH: ignored.
- Z80 read, addr 0:
  - z80_dout is loaded on the edge after z80_rd (1-cycle latency).
  - Non-empty: data = FIFO head, then pop.
  - Empty: data = EMPTY_VAL, no pointer change.
- Z80 read, addr 1..NUM_CH-1: non-destructive; data = latch value.
- Z80 read, addr >= NUM_CH: data = 0.
- z80_dout holds its value until the next z80_rd.
- Simultaneous push and pop on channel 0:
  - Both occur; count unchanged.
  - When full, the write is accepted (slot freed by the pop); host_ovf unchanged.
  - When empty, the read returns EMPTY_VAL and the write is stored. There is no bypass.
- Simultaneous host write and Z80 read of the same latch: the read returns the old value.
- Status outputs, all registered and reflecting post-edge state:
  - host_full = (count == FIFO_DEPTH).
  - z80_irq_n = (count == 0).
- host_ovf_clr with a same-cycle overflow event: set wins.
- Count arithmetic is CNT_W bits; it never exceeds FIFO_DEPTH and never underflows.

Optional Feature:
- Macro CPS_SND_REPLY_EN.
- Defined:
  - z80_wr loads z80_din into host_reply and sets host_reply_vld.
  - host_reply_ack clears host_reply_vld.
  - On a same-cycle z80_wr and host_reply_ack, the write wins: valid stays 1 with the new data.
- Undefined:
  - z80_wr, z80_din and host_reply_ack are ignored.
  - host_reply is constant 0 and host_reply_vld is constant 0.
  - No reply registers are synthesised.

Test Plan:
1. Reset, then Z80 read addr 0 -> z80_dout=8'hFF, z80_irq_n=1, host_count=0.
2. Host writes F0, F7, 09 to addr 0 -> host_count=3, z80_irq_n=0. Three Z80 reads of addr 0 -> F0, F7, 09 in order. A fourth read -> FF; z80_irq_n=1 after the third pop.
3. Depth 4: write 01..05 to addr 0 -> host_full=1 after 04, host_ovf=1, 05 dropped. Reads -> 01..04. host_ovf_clr -> host_ovf=0.
4. FIFO full, same-cycle host write 0A and Z80 read -> read returns the oldest entry, 0A is queued, count stays 4, host_ovf stays 0.
5. Host write 3C to addr 1, then two Z80 reads of addr 1 -> 3C both times, FIFO count unaffected. Assert reset_n low mid-sequence -> all outputs at reset values at once.
6. With CPS_SND_REPLY_EN: z80_wr with 5A -> host_reply=5A, host_reply_vld=1; host_reply_ack -> valid 0. Without the macro: host_reply_vld stays 0.
